// File: rtl/pipe_control.sv
// Main control for the 5-stage MIPS pipeline: ID decode, branch/jump resolution,
// ID/EX -> EX/MEM -> MEM/WB control bundles, front-end stall/flush and MULT busy FSM.
module pipe_control #(
    parameter int unsigned ALU_OP_W    = 2,
    parameter int unsigned MULT_CYCLES = 4,
    parameter logic [5:0]  MULT_FUNCT  = 6'b011000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                id_valid,
    input  logic                branch_eq,
    input  logic                load_use_hazard,
    output logic [1:0]          if_pc_source,
    output logic                if_flush,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                id_rt_is_source,
    output logic                mult_busy,
    output logic                ex_imm_command,
    output logic                ex_alu_src_b,
    output logic                ex_dst_reg_sel,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_mult_start,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_mem_to_reg,
    output logic                wb_reg_write,
    output logic                wb_link
);

    localparam int unsigned CNT_W = $clog2(MULT_CYCLES) + 1;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = '0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_FN  = ALU_OP_W'(2);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic {IDLE, BUSY} state_t;

    logic                d_imm, d_alu_src_b, d_dst, d_mult;
    logic [ALU_OP_W-1:0] d_alu_op;
    logic                d_mem_read, d_mem_write, d_mem_to_reg, d_reg_write, d_link;
    logic                is_beq, is_bne, is_jmp;
    logic                stall, mult_issue;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;

    logic ex_mem_read_q, ex_mem_write_q, ex_mem_to_reg_q, ex_reg_write_q, ex_link_q;
    logic mem_mem_to_reg_q, mem_reg_write_q, mem_link_q;

    always_comb begin
        d_imm           = 1'b0;
        d_alu_src_b     = 1'b0;
        d_dst           = 1'b0;
        d_mult          = 1'b0;
        d_alu_op        = ALU_ADD;
        d_mem_read      = 1'b0;
        d_mem_write     = 1'b0;
        d_mem_to_reg    = 1'b0;
        d_reg_write     = 1'b0;
        d_link          = 1'b0;
        is_beq          = 1'b0;
        is_bne          = 1'b0;
        is_jmp          = 1'b0;
        id_rt_is_source = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    d_dst           = 1'b1;
                    d_alu_op        = ALU_FN;
                    id_rt_is_source = 1'b1;
                    if (funct == MULT_FUNCT) d_mult = 1'b1;
                    else                     d_reg_write = 1'b1;
                end
                OP_LW: begin
                    d_alu_src_b  = 1'b1;
                    d_mem_read   = 1'b1;
                    d_mem_to_reg = 1'b1;
                    d_reg_write  = 1'b1;
                end
                OP_SW: begin
                    d_alu_src_b     = 1'b1;
                    d_mem_write     = 1'b1;
                    id_rt_is_source = 1'b1;
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                    d_alu_src_b = 1'b1;
                    d_imm       = 1'b1;
                    d_alu_op    = ALU_FN;
                    d_reg_write = 1'b1;
                end
                OP_BEQ: begin
                    d_alu_op        = ALU_SUB;
                    is_beq          = 1'b1;
                    id_rt_is_source = 1'b1;
                end
                OP_BNE: begin
                    d_alu_op        = ALU_SUB;
                    is_bne          = 1'b1;
                    id_rt_is_source = 1'b1;
                end
                OP_J:   is_jmp = 1'b1;
                OP_JAL: begin
                    is_jmp      = 1'b1;
                    d_reg_write = 1'b1;
                    d_link      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mult_busy  = (state == BUSY);
    assign stall      = load_use_hazard | mult_busy;
    assign mult_issue = d_mult & ~stall;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;

    // Control transfers are held off while stalled so they resolve with the released instruction.
    always_comb begin
        if_pc_source = 2'b00;
        if_flush     = 1'b0;
        if (!stall) begin
            if ((is_beq & branch_eq) | (is_bne & ~branch_eq)) begin
                if_pc_source = 2'b01;
                if_flush     = 1'b1;
            end else if (is_jmp) begin
                if_pc_source = 2'b10;
                if_flush     = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (mult_issue) begin
                state_next = BUSY;
                cnt_next   = CNT_W'(MULT_CYCLES - 1);
            end
            BUSY: if (cnt == '0) state_next = IDLE;
                  else           cnt_next   = cnt - CNT_W'(1);
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_imm_command   <= 1'b0;
            ex_alu_src_b     <= 1'b0;
            ex_dst_reg_sel   <= 1'b0;
            ex_alu_op        <= '0;
            ex_mult_start    <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_mem_to_reg_q  <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_link_q        <= 1'b0;
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_link_q       <= 1'b0;
            wb_mem_to_reg    <= 1'b0;
            wb_reg_write     <= 1'b0;
            wb_link          <= 1'b0;
        end else begin
            ex_imm_command   <= d_imm & ~stall;
            ex_alu_src_b     <= d_alu_src_b & ~stall;
            ex_dst_reg_sel   <= d_dst & ~stall;
            ex_alu_op        <= stall ? '0 : d_alu_op;
            ex_mult_start    <= mult_issue;
            ex_mem_read_q    <= d_mem_read & ~stall;
            ex_mem_write_q   <= d_mem_write & ~stall;
            ex_mem_to_reg_q  <= d_mem_to_reg & ~stall;
            ex_reg_write_q   <= d_reg_write & ~stall;
            ex_link_q        <= d_link & ~stall;
            mem_read         <= ex_mem_read_q;
            mem_write        <= ex_mem_write_q;
            mem_mem_to_reg_q <= ex_mem_to_reg_q;
            mem_reg_write_q  <= ex_reg_write_q;
            mem_link_q       <= ex_link_q;
            wb_mem_to_reg    <= mem_mem_to_reg_q;
            wb_reg_write     <= mem_reg_write_q;
            wb_link          <= mem_link_q;
        end
    end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: cycle-level behavioural model checked every cycle,
// plus hand-computed literal expectations for the main scenarios.
module tb_pipe_control;

    localparam int MC = 4;
    localparam logic [5:0] MF = 6'b011000;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] XORI = 6'b001110;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       id_valid, branch_eq, load_use_hazard;
    logic [1:0] if_pc_source;
    logic       if_flush, pc_write, ifid_write, id_rt_is_source, mult_busy;
    logic       ex_imm_command, ex_alu_src_b, ex_dst_reg_sel, ex_mult_start;
    logic [1:0] ex_alu_op;
    logic       mem_read, mem_write, wb_mem_to_reg, wb_reg_write, wb_link;

    pipe_control #(.ALU_OP_W(2), .MULT_CYCLES(MC), .MULT_FUNCT(MF)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .id_valid(id_valid),
        .branch_eq(branch_eq), .load_use_hazard(load_use_hazard),
        .if_pc_source(if_pc_source), .if_flush(if_flush), .pc_write(pc_write),
        .ifid_write(ifid_write), .id_rt_is_source(id_rt_is_source), .mult_busy(mult_busy),
        .ex_imm_command(ex_imm_command), .ex_alu_src_b(ex_alu_src_b),
        .ex_dst_reg_sel(ex_dst_reg_sel), .ex_alu_op(ex_alu_op), .ex_mult_start(ex_mult_start),
        .mem_read(mem_read), .mem_write(mem_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_link(wb_link)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imm, src_b, dst;
        logic [1:0] alu;
        logic       mult, mrd, mwr, m2r, rw, link;
    } bnd_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_issue = -1000;
    bnd_t m_ex = '0, m_mem = '0, m_wb = '0;

    function automatic bnd_t dec(logic [5:0] op, logic [5:0] fn, logic v);
        bnd_t b = '0;
        if (v) begin
            case (op)
                RT: begin
                    b.dst = 1'b1; b.alu = 2'b10;
                    if (fn == MF) b.mult = 1'b1; else b.rw = 1'b1;
                end
                LW: begin b.src_b = 1'b1; b.mrd = 1'b1; b.m2r = 1'b1; b.rw = 1'b1; end
                SW: begin b.src_b = 1'b1; b.mwr = 1'b1; end
                ADDI, ANDI, ORI, XORI, SLTI: begin
                    b.src_b = 1'b1; b.imm = 1'b1; b.alu = 2'b10; b.rw = 1'b1;
                end
                BEQ, BNE: b.alu = 2'b01;
                JAL: begin b.rw = 1'b1; b.link = 1'b1; end
                default: ;
            endcase
        end
        return b;
    endfunction

    // The MULT issued at cycle last_issue keeps the machine busy for the next MC cycles.
    function automatic logic m_busy();
        return (cyc > last_issue) && (cyc <= last_issue + MC);
    endfunction

    function automatic logic [1:0] exp_pc(logic [5:0] op, logic v, logic eq, logic st);
        if (st || !v) return 2'b00;
        if ((op == BEQ && eq) || (op == BNE && !eq)) return 2'b01;
        if (op == J || op == JAL) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_issue <= -1000;
            m_ex  <= '0;
            m_mem <= '0;
            m_wb  <= '0;
        end else begin
            if (!(load_use_hazard || m_busy()) && dec(opcode, funct, id_valid).mult)
                last_issue <= cyc;
            m_wb  <= m_mem;
            m_mem <= m_ex;
            m_ex  <= (load_use_hazard || m_busy()) ? '0 : dec(opcode, funct, id_valid);
            cyc   <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        logic st;
        logic [1:0] pcs;
        logic rt;
        st  = load_use_hazard || m_busy();
        pcs = exp_pc(opcode, id_valid, branch_eq, st);
        rt  = id_valid && (opcode == RT || opcode == BEQ || opcode == BNE || opcode == SW);
        chk("m_pc_source", 8'(if_pc_source), 8'(pcs));
        chk("m_flush",     8'(if_flush),     8'(pcs != 2'b00));
        chk("m_pc_write",  8'(pc_write),     8'(!st));
        chk("m_ifid_write",8'(ifid_write),   8'(!st));
        chk("m_rt_src",    8'(id_rt_is_source), 8'(rt));
        chk("m_mult_busy", 8'(mult_busy),    8'(m_busy()));
        chk("m_ex_imm",    8'(ex_imm_command), 8'(m_ex.imm));
        chk("m_ex_src_b",  8'(ex_alu_src_b), 8'(m_ex.src_b));
        chk("m_ex_dst",    8'(ex_dst_reg_sel), 8'(m_ex.dst));
        chk("m_ex_alu_op", 8'(ex_alu_op),    8'(m_ex.alu));
        chk("m_ex_mult",   8'(ex_mult_start), 8'(m_ex.mult));
        chk("m_mem_read",  8'(mem_read),     8'(m_mem.mrd));
        chk("m_mem_write", 8'(mem_write),    8'(m_mem.mwr));
        chk("m_wb_m2r",    8'(wb_mem_to_reg), 8'(m_wb.m2r));
        chk("m_wb_rw",     8'(wb_reg_write), 8'(m_wb.rw));
        chk("m_wb_link",   8'(wb_link),      8'(m_wb.link));
    end

    task automatic cy(logic [5:0] op, logic [5:0] fn, logic v, logic eq, logic hz);
        @(posedge clk);
        #1;
        opcode = op; funct = fn; id_valid = v; branch_eq = eq; load_use_hazard = hz;
        @(negedge clk);
        #1;
    endtask

    task automatic nop();
        cy(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = '0; funct = '0; id_valid = 1'b0; branch_eq = 1'b0; load_use_hazard = 1'b0;

        // Reset, then LW through all three stages
        @(negedge clk); #1;
        chk("rst_busy", 8'(mult_busy), 8'd0);
        chk("rst_ex_alu_op", 8'(ex_alu_op), 8'd0);
        chk("rst_wb_rw", 8'(wb_reg_write), 8'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        cy(LW, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("lw_n_ex_src_b", 8'(ex_alu_src_b), 8'd0);
        chk("lw_n_mem_read", 8'(mem_read), 8'd0);
        nop();
        chk("lw_n1_ex_src_b", 8'(ex_alu_src_b), 8'd1);
        chk("lw_n1_ex_alu_op", 8'(ex_alu_op), 8'd0);
        nop();
        chk("lw_n2_mem_read", 8'(mem_read), 8'd1);
        nop();
        chk("lw_n3_wb_m2r", 8'(wb_mem_to_reg), 8'd1);
        chk("lw_n3_wb_rw", 8'(wb_reg_write), 8'd1);

        // Assorted decode
        cy(SW, 6'd0, 1'b1, 1'b0, 1'b0);
        cy(RT, 6'b100000, 1'b1, 1'b0, 1'b0);
        cy(ORI, 6'd0, 1'b1, 1'b0, 1'b0);
        cy(J, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("j_pc_src", 8'(if_pc_source), 8'd2);

        // Branches
        cy(BEQ, 6'd0, 1'b1, 1'b1, 1'b0);
        chk("beq_pc_src", 8'(if_pc_source), 8'd1);
        chk("beq_flush", 8'(if_flush), 8'd1);
        cy(BNE, 6'd0, 1'b1, 1'b1, 1'b0);
        chk("bne_pc_src", 8'(if_pc_source), 8'd0);
        chk("bne_flush", 8'(if_flush), 8'd0);
        cy(JAL, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("jal_pc_src", 8'(if_pc_source), 8'd2);
        chk("jal_flush", 8'(if_flush), 8'd1);
        nop(); nop(); nop();
        chk("jal_wb_link", 8'(wb_link), 8'd1);
        chk("jal_wb_rw", 8'(wb_reg_write), 8'd1);

        // MULT followed by ADDI held in ID
        cy(RT, MF, 1'b1, 1'b0, 1'b0);
        chk("mult_n_pc_write", 8'(pc_write), 8'd1);
        chk("mult_n_start", 8'(ex_mult_start), 8'd0);
        cy(ADDI, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("mult_n1_start", 8'(ex_mult_start), 8'd1);
        chk("mult_n1_busy", 8'(mult_busy), 8'd1);
        for (int k = 2; k <= 4; k++) begin
            cy(ADDI, 6'd0, 1'b1, 1'b0, 1'b0);
            chk("mult_bubble_start", 8'(ex_mult_start), 8'd0);
            chk("mult_bubble_busy", 8'(mult_busy), 8'd1);
            chk("mult_bubble_pc_write", 8'(pc_write), 8'd0);
            chk("mult_bubble_alu_op", 8'(ex_alu_op), 8'd0);
        end
        cy(ADDI, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("mult_n5_busy", 8'(mult_busy), 8'd0);
        chk("mult_n5_pc_write", 8'(pc_write), 8'd1);
        nop();
        chk("mult_n6_imm", 8'(ex_imm_command), 8'd1);

        // Load-use hazard against MULT and taken BEQ
        cy(RT, MF, 1'b1, 1'b0, 1'b1);
        chk("hz_mult_pc_write", 8'(pc_write), 8'd0);
        nop();
        chk("hz_mult_busy", 8'(mult_busy), 8'd0);
        chk("hz_mult_start", 8'(ex_mult_start), 8'd0);
        cy(BEQ, 6'd0, 1'b1, 1'b1, 1'b1);
        chk("hz_beq_pc_src", 8'(if_pc_source), 8'd0);
        cy(BEQ, 6'd0, 1'b1, 1'b1, 1'b0);
        chk("beq_release_pc_src", 8'(if_pc_source), 8'd1);

        // Asynchronous reset while BUSY with the counter at 2
        cy(RT, MF, 1'b1, 1'b0, 1'b0);
        cy(ADDI, 6'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("mid_busy_before", 8'(mult_busy), 8'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_busy_async", 8'(mult_busy), 8'd0);
        chk("mid_pc_write", 8'(pc_write), 8'd1);
        chk("mid_ex_alu_op", 8'(ex_alu_op), 8'd0);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        nop(); nop(); nop();
        cy(RT, MF, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= MC; k++) begin
            nop();
            chk("re_mult_busy", 8'(mult_busy), 8'd1);
        end
        nop();
        chk("re_mult_idle", 8'(mult_busy), 8'd0);
        nop(); nop(); nop();

        // Illegal opcode and id_valid=0 give bubbles
        cy(6'b111111, 6'd0, 1'b1, 1'b0, 1'b0);
        chk("ill_pc_write", 8'(pc_write), 8'd1);
        cy(LW, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("ill_ex_src_b", 8'(ex_alu_src_b), 8'd0);
        chk("nv_rt_src", 8'(id_rt_is_source), 8'd0);
        nop();
        chk("nv_ex_src_b", 8'(ex_alu_src_b), 8'd0);
        chk("ill_mem_read", 8'(mem_read), 8'd0);
        nop();
        chk("nv_mem_read", 8'(mem_read), 8'd0);
        chk("ill_wb_rw", 8'(wb_reg_write), 8'd0);
        nop();
        chk("nv_wb_rw", 8'(wb_reg_write), 8'd0);
        chk("nv_pc_write", 8'(pc_write), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Second-generation main control for the 5-stage MIPS pipeline.
- Decodes the ID-stage opcode and funct, and resolves BEQ/BNE/J/JAL in ID.
- Carries control bundles through registered ID/EX, EX/MEM and MEM/WB stages.
- Generates front-end stall and flush. Issues a multi-cycle MULT with a parametrised busy stall.

Parameters:
- ALU_OP_W, 2: width of ex_alu_op (>=2); codes are zero-extended: 00 add, 01 sub, 10 funct-defined.
- MULT_CYCLES, 4: cycles the front-end stalls after a MULT issues (>=1).
- MULT_FUNCT, 6'b011000: R-type funct code that selects MULT.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  ID-stage instruction [31:26].
- funct  input  6  ID-stage instruction [5:0].
- id_valid  input  1  ID holds a real instruction; 0 means decode as NOP.
- branch_eq  input  1  ID-stage rs==rt comparison.
- load_use_hazard  input  1  stall request from the hazard unit.
- if_pc_source  output  2  00 PC+4, 01 branch target, 10 jump target (combinational).
- if_flush  output  1  squash IF/ID (combinational).
- pc_write  output  1  PC enable (combinational).
- ifid_write  output  1  IF/ID enable (combinational).
- id_rt_is_source  output  1  rt is read as a source (R-type, BEQ, BNE, SW) (combinational).
- mult_busy  output  1  FSM is in BUSY.
- ex_imm_command  output  1  registered; ID/EX stage.
- ex_alu_src_b  output  1  registered; ID/EX stage.
- ex_dst_reg_sel  output  1  registered; ID/EX stage.
- ex_alu_op  output  ALU_OP_W  registered; ID/EX stage.
- ex_mult_start  output  1  registered; ID/EX stage.
- mem_read  output  1  registered; EX/MEM stage.
- mem_write  output  1  registered; EX/MEM stage.
- wb_mem_to_reg  output  1  registered; MEM/WB stage.
- wb_reg_write  output  1  registered; MEM/WB stage.
- wb_link  output  1  registered; MEM/WB stage; write PC+8 to r31.

Behaviour:
- Decode: combinational, with all-zero defaults. Unknown opcode or id_valid=0 decodes as NOP (all zeros).
- LW: alu_src_b=1, alu_op=add, mem_read=1, mem_to_reg=1, reg_write=1.
- SW: alu_src_b=1, alu_op=add, mem_write=1.
- R-type: dst_reg_sel=1, alu_op=10, reg_write=1. When funct==MULT_FUNCT, also mult_start=1 and reg_write=0.
- ADDI/ANDI/ORI/XORI/SLTI: alu_src_b=1, imm_command=1, alu_op=10, reg_write=1.
- BEQ/BNE: alu_op=sub, no writes.
- J: no writes.
- JAL: reg_write=1, link=1.
- stall = load_use_hazard | mult_busy. When stall=1:
  - pc_write=0, ifid_write=0.
  - ID/EX loads an all-zero bubble.
  - if_pc_source=00, if_flush=0; branches and jumps resolve only once the stall clears.
  - A MULT is not issued.
- When stall=0:
  - pc_write=1, ifid_write=1.
  - BEQ with branch_eq=1, or BNE with branch_eq=0: if_pc_source=01, if_flush=1.
  - J/JAL: if_pc_source=10, if_flush=1.
  - Otherwise if_pc_source=00, if_flush=0.
- Latency: bundle decoded in cycle N appears on ex_* in N+1, mem_* in N+2, wb_* in N+3.
- EX/MEM and MEM/WB always advance; bubbles drain normally.
- MULT FSM, states IDLE and BUSY, with a counter of width clog2(MULT_CYCLES)+1:
  - IDLE -> BUSY: at the edge ending cycle N, when a MULT is in ID with id_valid=1 and stall=0. Counter loads MULT_CYCLES-1; the MULT enters ID/EX with ex_mult_start=1 for exactly one cycle.
  - BUSY: the counter decrements each cycle. When the counter is 0, go to IDLE.
  - mult_busy is high for exactly MULT_CYCLES cycles, N+1 through N+MULT_CYCLES.
  - The instruction after the MULT stays in ID and issues in cycle N+MULT_CYCLES+1.
  - A MULT arriving in ID while BUSY waits; back-to-back MULTs are spaced by MULT_CYCLES stall cycles.
- Simultaneous load_use_hazard and MULT in ID: the hazard wins and the MULT waits.
- Reset (rst_n=0, asynchronous, any time including mid-MULT):
  - All pipeline registers clear to 0; FSM goes to IDLE; counter=0.
  - mult_busy=0 immediately; combinational outputs then follow the inputs with stall=load_use_hazard.
- No X on outputs after reset for any opcode value.

Test Plan:
- Reset mid-op: assert rst_n=0 for 2 cycles, then issue LW (100011) id_valid=1 -> N+1 ex_alu_src_b=1, ex_alu_op=00; N+2 mem_read=1; N+3 wb_mem_to_reg=1, wb_reg_write=1; all outputs 0 before this.
- Branches: BEQ with branch_eq=1 -> if_pc_source=01, if_flush=1. BNE with branch_eq=1 -> 00, flush 0. JAL -> 10, flush=1, and wb_link=1, wb_reg_write=1 three cycles later.
- MULT, MULT_CYCLES=4: MULT in cycle N with ADDI behind it -> ex_mult_start=1 in N+1 only; mult_busy=1 in N+1..N+4; pc_write=0 and ex_* all zero in N+2..N+4 (bubbles); ADDI ex_imm_command=1 in N+6.
- Load-use hazard with MULT and BEQ: load_use_hazard=1 with MULT in ID -> no issue, mult_busy stays 0; hazard=1 with taken BEQ -> if_pc_source=00; hazard drops -> 01 in the same cycle.
- Reset mid-BUSY: pulse rst_n low at counter=2 -> mult_busy=0 asynchronously, FSM IDLE, pipeline registers 0; the next MULT gets the full MULT_CYCLES stall.
- Illegal opcode/id_valid=0: opcode 111111, then id_valid=0 with LW -> three-stage bubble, all ex_/mem_/wb_ outputs 0, pc_write=1.
